// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; flags the fourth byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word_out,
  output logic        word_done
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] low_q, low_d;

  always_comb begin
    lane_d = lane_q;
    low_d  = low_q;
    if (clr) begin
      lane_d = '0;
      low_d  = '0;
    end else if (byte_en) begin
      case (lane_q)
        2'd0:    low_d[7:0]   = byte_in;
        2'd1:    low_d[15:8]  = byte_in;
        2'd2:    low_d[23:16] = byte_in;
        default: ;
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  // Top byte comes straight from the input so the word is complete on the lane-3 accept.
  assign word_done = byte_en && !clr && (lane_q == 2'(BYTES_PER_WORD - 1));
  assign word_out  = {byte_in, low_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      low_q  <= '0;
    end else begin
      lane_q <= lane_d;
      low_q  <= low_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/payload/checksum stream, writes instruction memory,
// then releases the core via cpu_run.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          cpu_run,
  output logic          error
);

  localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       csum_q, csum_d;

  logic             byte_ready_q, busy_q, cpu_run_q, error_q, wr_en_q;
  logic [31:0]      wr_addr_q, wr_data_q;

  logic                     accept;
  logic                     asm_clr, asm_en, word_done;
  logic [31:0]              word_out;
  logic [8*HDR_BYTES-1:0]   hdr_raw;
  logic [CNT_W-1:0]         hdr_n;
  logic                     restartable, load_active_d;

  assign accept      = bus.byte_valid && byte_ready_q;
  assign restartable = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign asm_clr     = start && restartable;
  assign asm_en      = accept && (state_q == ST_DATA);
  assign hdr_raw     = {bus.byte_data, len_lo_q};
  assign hdr_n       = CNT_W'(hdr_raw);

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .byte_in   (bus.byte_data),
    .byte_en   (asm_en),
    .word_out  (word_out),
    .word_done (word_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    csum_d   = csum_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.byte_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = hdr_n;
          if (hdr_n == '0)                state_d = ST_CSUM;
          else if (32'(hdr_n) > DEPTH)    state_d = ST_ERR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q + bus.byte_data;
          if (word_done) begin
            idx_d = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (bus.byte_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_active_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                         (state_d == ST_DATA)   || (state_d == ST_CSUM);

  // Status outputs are registered from the next state so they track the FSM with no extra lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_lo_q     <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      cpu_run_q    <= 1'b0;
      error_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      byte_ready_q <= load_active_d;
      busy_q       <= load_active_d;
      cpu_run_q    <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
      wr_en_q      <= asm_en && word_done;
      if (asm_en && word_done) begin
        wr_addr_q <= 32'(idx_q) << 2;
        wr_data_q <= word_out;
      end
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = busy_q;
  assign cpu_run        = cpu_run_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, popped by a monitor.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, cpu_run, error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(1024), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .cpu_run (cpu_run),
    .error   (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, expv);
    end
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write strobe must match the head of the scoreboard and last one cycle.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      chk("wr_en_width", {31'd0, prev_wr}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.wr_addr, bus.wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, e[63:32]);
        chk("wr_data", bus.wr_data, e[31:0]);
      end
    end
    prev_wr = bus.wr_en;
  end

  // All tasks below are entered and left at a falling edge.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_ready", {31'd0, bus.byte_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      total++;
      bad++;
      $display("FAIL byte_timeout got=ready0 want=ready1 byte=%h", b);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap);
    for (int i = 0; i < s.size(); i++) begin
      if (i == s.size() - 1) chk("cpu_run_before_last", {31'd0, cpu_run}, 32'd0);
      send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({tag, "_wr_en"},      {31'd0, bus.wr_en},      32'd0);
    chk({tag, "_wr_addr"},    bus.wr_addr,             32'd0);
    chk({tag, "_wr_data"},    bus.wr_data,             32'd0);
    chk({tag, "_busy"},       {31'd0, busy},           32'd0);
    chk({tag, "_cpu_run"},    {31'd0, cpu_run},        32'd0);
    chk({tag, "_error"},      {31'd0, error},          32'd0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd1);
    chk({tag, "_error"},   {31'd0, error},   32'd0);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_error"},   {31'd0, error},          32'd1);
    chk({tag, "_cpu_run"}, {31'd0, cpu_run},        32'd0);
    chk({tag, "_busy"},    {31'd0, busy},           32'd0);
    chk({tag, "_ready"},   {31'd0, bus.byte_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Payload bytes 13+93+10 sum to 0xB6; header bytes are not part of the checksum.
    logic [7:0] good[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    logic [7:0] badc[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hC8};
    logic [7:0] big[$]  = '{8'h01, 8'h04};
    logic [7:0] zero[$] = '{8'h00, 8'h00, 8'h00};
    // Words DEADBEEF, 12345678, 000000FF; payload sum mod 256 = 0x4B.
    logic [7:0] three[$] = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'h00,
                             8'h00, 8'h00, 8'h4B};
    logic [7:0] part[$];

    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load.
    exp_write(32'h0, 32'h0000_0013);
    exp_write(32'h4, 32'h0010_0093);
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send_stream(good, 0);
    chk_done("t1");
    chk("t1_addr_hold", bus.wr_addr, 32'h4);
    chk("t1_data_hold", bus.wr_data, 32'h0010_0093);

    // Bad checksum, then recovery.
    exp_write(32'h0, 32'h0000_0013);
    exp_write(32'h4, 32'h0010_0093);
    pulse_start();
    chk("t2_cpu_run_dropped", {31'd0, cpu_run}, 32'd0);
    send_stream(badc, 0);
    chk_err("t2");
    exp_write(32'h0, 32'h0000_0013);
    exp_write(32'h4, 32'h0010_0093);
    pulse_start();
    chk("t2_error_cleared", {31'd0, error}, 32'd0);
    send_stream(good, 0);
    chk_done("t2r");

    // Oversized count: error straight after the length header, no writes.
    pulse_start();
    send_stream(big, 0);
    chk_err("t3");
    repeat (4) @(negedge clk);
    chk("t3_pending", 32'(exp_q.size()), 32'd0);

    // Empty image.
    pulse_start();
    send_stream(zero, 0);
    chk_done("t4");

    // Three words with random valid gaps.
    exp_write(32'h0, 32'hDEAD_BEEF);
    exp_write(32'h4, 32'h1234_5678);
    exp_write(32'h8, 32'h0000_00FF);
    pulse_start();
    send_stream(three, 3);
    chk_done("t5");

    // Reset mid-payload, then a clean reload.
    for (int i = 0; i < 8; i++) part.push_back(good[i]);
    exp_write(32'h0, 32'h0000_0013);
    pulse_start();
    send_stream(part, 0);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    exp_write(32'h0, 32'h0000_0013);
    exp_write(32'h4, 32'h0010_0093);
    pulse_start();
    send_stream(good, 0);
    chk_done("t6");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
